// File: rtl/mem_ctrl_burst_pkg.sv
// Shared types and helpers for the byte-serial burst memory controller:
// FSM state encoding, load/store size codes, IO region tag, size and extension helpers.
package mem_ctrl_burst_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_INST = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] IO_REGION_HI = 2'b11;

    // Number of RAM bytes moved by one granted access.
    function automatic logic [7:0] byte_count(input logic is_inst, input logic [2:0] f3,
                                              input int line_words);
        if (is_inst) begin
            return 8'(4 * line_words);
        end
        case (f3)
            F3_B, F3_BU: return 8'd1;
            F3_H, F3_HU: return 8'd2;
            default:     return 8'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            F3_B:    return {{24{raw[7]}}, raw[7:0]};
            F3_H:    return {{16{raw[15]}}, raw[15:0]};
            F3_BU:   return {24'h0, raw[7:0]};
            F3_HU:   return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_burst_if.sv
// Client-side bundle of the controller: LSB data port, icache refill port, flush and busy.
interface mem_ctrl_burst_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int ID_W       = 3
);
    logic                    d_req;
    logic                    d_we;
    logic [ADDR_W-1:0]       d_addr;
    logic [31:0]             d_wdata;
    logic [2:0]              d_funct3;
    logic [ID_W-1:0]         d_id;
    logic                    d_done;
    logic [31:0]             d_rdata;
    logic [ID_W-1:0]         d_id_out;

    logic                    i_req;
    logic [ADDR_W-1:0]       i_addr;
    logic                    i_done;
    logic [32*LINE_WORDS-1:0] i_line;
    logic [ADDR_W-1:0]       i_addr_out;

    logic                    flush;
    logic                    busy;

    modport master (
        output d_req, d_we, d_addr, d_wdata, d_funct3, d_id,
        input  d_done, d_rdata, d_id_out,
        output i_req, i_addr,
        input  i_done, i_line, i_addr_out,
        output flush,
        input  busy
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, d_funct3, d_id,
        output d_done, d_rdata, d_id_out,
        input  i_req, i_addr,
        output i_done, i_line, i_addr_out,
        input  flush,
        output busy
    );

endinterface

// File: rtl/mem_ctrl_burst_arbiter.sv
// Grant selection between data and instruction requests.
// MEM_CTRL_RR_EN selects round-robin; otherwise data always wins.
module mem_ctrl_arbiter (
    input  logic d_req_i,
    input  logic i_req_i,
    input  logic last_inst_i,
    output logic gnt_d_o,
    output logic gnt_i_o
);

`ifdef MEM_CTRL_RR_EN
    // On contention the port that was not granted last goes first.
    always_comb begin
        gnt_d_o = d_req_i && (!i_req_i || last_inst_i);
        gnt_i_o = i_req_i && (!d_req_i || !last_inst_i);
    end
`else
    logic unused_last;

    assign unused_last = last_inst_i;
    assign gnt_d_o     = d_req_i;
    assign gnt_i_o     = i_req_i && !d_req_i;
`endif

endmodule

// File: rtl/mem_ctrl_burst.sv
// Byte-serial RAM controller arbitrating LSB accesses and icache line refills.
// Define MEM_CTRL_RR_EN for round-robin arbitration instead of data-first priority.
module mem_ctrl_burst
    import mem_ctrl_burst_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         LINE_WORDS = 4,
    parameter int         ID_W       = 3,
    parameter logic [1:0] IO_HI      = IO_REGION_HI
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_aout,
    output logic              mem_wr,
    mem_ctrl_burst_if.slave   bus
);

    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int LINE_B = 4 * LINE_WORDS;

    state_e              state_q;
    logic [7:0]          cnt_q;
    logic [7:0]          nbytes_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [23:0]         wdata_q;
    logic [ID_W-1:0]     id_q;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   line_d;
    logic [ADDR_W-1:0]   mem_aout_q;
    logic [7:0]          mem_dout_q;
    logic                wr_q;
    logic                d_done_q;
    logic [31:0]         d_rdata_q;
    logic [ID_W-1:0]     d_id_out_q;
    logic                i_done_q;
    logic [LINE_W-1:0]   i_line_q;
    logic [ADDR_W-1:0]   i_addr_out_q;
    logic                last_inst_q;
    logic                gnt_d;
    logic                gnt_i;
    logic                stall;

    mem_ctrl_arbiter u_arb (
        .d_req_i     (bus.d_req),
        .i_req_i     (bus.i_req),
        .last_inst_i (last_inst_q),
        .gnt_d_o     (gnt_d),
        .gnt_i_o     (gnt_i)
    );

    assign stall = (state_q == S_DATA) && we_q && (addr_q[17:16] == IO_HI) && io_buffer_full;

    // mem_din carries byte cnt_q-1: the RAM answers one cycle after the address.
    always_comb begin
        line_d = line_q;
        for (int b = 0; b < LINE_B; b++) begin
            if (cnt_q == 8'(b + 1)) begin
                line_d[b*8 +: 8] = mem_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            nbytes_q     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            wdata_q      <= '0;
            id_q         <= '0;
            line_q       <= '0;
            mem_aout_q   <= '0;
            mem_dout_q   <= '0;
            wr_q         <= 1'b0;
            d_done_q     <= 1'b0;
            d_rdata_q    <= '0;
            d_id_out_q   <= '0;
            i_done_q     <= 1'b0;
            i_line_q     <= '0;
            i_addr_out_q <= '0;
            last_inst_q  <= 1'b1;
        end else if (rdy_in) begin
            d_done_q <= 1'b0;
            i_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Requests stay high through the done cycle, so no grant then.
                    if (!d_done_q && !i_done_q) begin
                        if (gnt_d) begin
                            state_q     <= S_DATA;
                            addr_q      <= bus.d_addr;
                            we_q        <= bus.d_we;
                            f3_q        <= bus.d_funct3;
                            id_q        <= bus.d_id;
                            nbytes_q    <= byte_count(1'b0, bus.d_funct3, LINE_WORDS);
                            cnt_q       <= '0;
                            line_q      <= '0;
                            mem_aout_q  <= bus.d_addr;
                            last_inst_q <= 1'b0;
                            if (bus.d_we) begin
                                mem_dout_q <= bus.d_wdata[7:0];
                                wdata_q    <= bus.d_wdata[31:8];
                                wr_q       <= 1'b1;
                            end
                        end else if (gnt_i) begin
                            state_q     <= S_INST;
                            addr_q      <= bus.i_addr;
                            we_q        <= 1'b0;
                            nbytes_q    <= byte_count(1'b1, F3_W, LINE_WORDS);
                            cnt_q       <= '0;
                            line_q      <= '0;
                            mem_aout_q  <= bus.i_addr;
                            last_inst_q <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (we_q) begin
                        if (!stall) begin
                            if (cnt_q == nbytes_q - 8'd1) begin
                                wr_q       <= 1'b0;
                                d_done_q   <= 1'b1;
                                d_id_out_q <= id_q;
                                cnt_q      <= '0;
                                state_q    <= S_IDLE;
                            end else begin
                                cnt_q      <= cnt_q + 8'd1;
                                mem_aout_q <= mem_aout_q + ADDR_W'(1);
                                mem_dout_q <= wdata_q[7:0];
                                wdata_q    <= {8'h00, wdata_q[23:8]};
                            end
                        end
                    end else if (cnt_q == nbytes_q) begin
                        d_done_q   <= 1'b1;
                        d_rdata_q  <= load_extend(line_d[31:0], f3_q);
                        d_id_out_q <= id_q;
                        cnt_q      <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q  <= cnt_q + 8'd1;
                        line_q <= line_d;
                        if (cnt_q < nbytes_q - 8'd1) begin
                            mem_aout_q <= mem_aout_q + ADDR_W'(1);
                        end
                    end
                end
                S_INST: begin
                    // Flush beats the final capture: the partial line is dropped.
                    if (bus.flush) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == nbytes_q) begin
                        i_done_q     <= 1'b1;
                        i_line_q     <= line_d;
                        i_addr_out_q <= addr_q;
                        cnt_q        <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q  <= cnt_q + 8'd1;
                        line_q <= line_d;
                        if (cnt_q < nbytes_q - 8'd1) begin
                            mem_aout_q <= mem_aout_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_wr         = wr_q && rdy_in && !stall;
    assign mem_aout       = mem_aout_q;
    assign mem_dout       = mem_dout_q;
    assign bus.d_done     = d_done_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.d_id_out   = d_id_out_q;
    assign bus.i_done     = i_done_q;
    assign bus.i_line     = i_line_q;
    assign bus.i_addr_out = i_addr_out_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Scoreboard bench for mem_ctrl_burst: directed loads, stores, IO stall, refill, flush and arbitration.
module tb_mem_ctrl_burst;
    import mem_ctrl_burst_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LW     = 4;
    localparam int ID_W   = 3;
    localparam logic [127:0] LINE_1000 = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;

    logic clk = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic io_buffer_full;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic [ADDR_W-1:0] mem_aout;
    logic mem_wr;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        bit           is_inst;
        bit           chk_rdata;
        logic [31:0]  rdata;
        logic [2:0]   id;
        logic [127:0] line;
        logic [31:0]  iaddr;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wexp_t;

    exp_t  exp_q[$];
    wexp_t wq[$];
    logic [7:0] ram [0:65535];

    mem_ctrl_burst_if #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .ID_W(ID_W)) bus ();

    mem_ctrl_burst #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .ID_W(ID_W)) dut (
        .clk            (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_aout       (mem_aout),
        .mem_wr         (mem_wr),
        .bus            (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (rst_in) begin
            for (int k = 0; k < 65536; k++) ram[k] <= 8'h00;
            ram[16'h0100] <= 8'h80;
            for (int k = 0; k < 16; k++) ram[16'h1000 + k] <= 8'(8'hA0 + k);
        end else if (mem_wr) begin
            ram[mem_aout[15:0]] <= mem_dout;
        end
        mem_din <= ram[mem_aout[15:0]];
    end

    // Completion monitor.
    always @(negedge clk) begin
        exp_t e;
        bit ok;
        if (!rst_in && (bus.d_done || bus.i_done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected d_done=%0b i_done=%0b cyc=%0d", bus.d_done, bus.i_done, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.is_inst)
                    ok = bus.i_done && !bus.d_done && (bus.i_line === e.line) &&
                         (bus.i_addr_out === e.iaddr) && (cyc == e.cyc);
                else
                    ok = bus.d_done && !bus.i_done && (bus.d_id_out === e.id) &&
                         (!e.chk_rdata || bus.d_rdata === e.rdata) && (cyc == e.cyc);
                if (!ok) begin
                    errors++;
                    $display("FAIL %s got d_done=%0b i_done=%0b rdata=%h id=%0d line=%h iaddr=%h cyc=%0d required rdata=%h id=%0d line=%h iaddr=%h cyc=%0d",
                             e.name, bus.d_done, bus.i_done, bus.d_rdata, bus.d_id_out, bus.i_line,
                             bus.i_addr_out, cyc, e.rdata, e.id, e.line, e.iaddr, e.cyc);
                end
            end
        end
    end

    // Write monitor.
    always @(negedge clk) begin
        wexp_t w;
        if (!rst_in && mem_wr) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%h data=%h cyc=%0d", mem_aout, mem_dout, cyc);
            end else begin
                w = wq.pop_front();
                if (mem_aout !== w.addr || mem_dout !== w.data || cyc != w.cyc) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                             mem_aout, mem_dout, cyc, w.addr, w.data, w.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic push_d(input string name, input bit chk_rd, input logic [31:0] rdata,
                          input logic [2:0] id, input int at);
        exp_t e;
        e.name = name; e.is_inst = 1'b0; e.chk_rdata = chk_rd; e.rdata = rdata; e.id = id;
        e.line = '0; e.iaddr = '0; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic push_i(input string name, input logic [127:0] line, input logic [31:0] iaddr,
                          input int at);
        exp_t e;
        e.name = name; e.is_inst = 1'b1; e.chk_rdata = 1'b0; e.rdata = '0; e.id = '0;
        e.line = line; e.iaddr = iaddr; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic push_w(input logic [31:0] addr, input logic [7:0] data, input int at);
        wexp_t w;
        w.addr = addr; w.data = data; w.cyc = at;
        wq.push_back(w);
    endtask

    task automatic do_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [2:0] id, input bit settle);
        int n = 0;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr;
        bus.d_wdata = wdata; bus.d_funct3 = f3; bus.d_id = id;
        do begin
            @(posedge clk); #1; n++;
        end while (!bus.d_done && n < 200);
        if (!bus.d_done) begin
            checks++; errors++;
            $display("FAIL timeout_data addr=%h got no d_done required d_done within 200 cycles", addr);
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        if (settle) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_inst(input logic [31:0] addr);
        int n = 0;
        bus.i_req = 1'b1; bus.i_addr = addr;
        do begin
            @(posedge clk); #1; n++;
        end while (!bus.i_done && n < 200);
        if (!bus.i_done) begin
            checks++; errors++;
            $display("FAIL timeout_inst addr=%h got no i_done required i_done within 200 cycles", addr);
        end
        bus.i_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int c;
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = '0; bus.d_id = '0;
        bus.i_req = 0; bus.i_addr = '0; bus.flush = 0;
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        chk("rst_busy", 128'(bus.busy), 128'h0);
        chk("rst_d_done", 128'(bus.d_done), 128'h0);
        chk("rst_i_done", 128'(bus.i_done), 128'h0);
        chk("rst_mem_wr", 128'(mem_wr), 128'h0);
        chk("rst_mem_aout", 128'(mem_aout), 128'h0);
        chk("rst_mem_dout", 128'(mem_dout), 128'h0);
        chk("rst_d_rdata", 128'(bus.d_rdata), 128'h0);
        chk("rst_i_line", bus.i_line, 128'h0);
        @(posedge clk); #1;

        push_d("lbu_100", 1, 32'h0000_0080, 3'd1, cyc + 3);
        do_data(1'b0, 32'h100, 32'h0, F3_BU, 3'd1, 1'b1);
        push_d("lb_100", 1, 32'hFFFF_FF80, 3'd2, cyc + 3);
        do_data(1'b0, 32'h100, 32'h0, F3_B, 3'd2, 1'b1);

        c = cyc;
        push_w(32'h200, 8'hEF, c + 1);
        push_w(32'h201, 8'hBE, c + 2);
        push_w(32'h202, 8'hAD, c + 3);
        push_w(32'h203, 8'hDE, c + 4);
        push_d("sw_200", 0, 32'h0, 3'd3, c + 5);
        do_data(1'b1, 32'h200, 32'hDEAD_BEEF, F3_W, 3'd3, 1'b1);

        push_d("lw_200", 1, 32'hDEAD_BEEF, 3'd4, cyc + 6);
        do_data(1'b0, 32'h200, 32'h0, F3_W, 3'd4, 1'b1);
        push_d("lh_202", 1, 32'hFFFF_DEAD, 3'd5, cyc + 4);
        do_data(1'b0, 32'h202, 32'h0, F3_H, 3'd5, 1'b1);
        push_d("lhu_200", 1, 32'h0000_BEEF, 3'd6, cyc + 4);
        do_data(1'b0, 32'h200, 32'h0, F3_HU, 3'd6, 1'b1);
        push_d("lb_201", 1, 32'hFFFF_FFBE, 3'd7, cyc + 3);
        do_data(1'b0, 32'h201, 32'h0, F3_B, 3'd7, 1'b1);

        // IO store held off by a full UART buffer for three cycles.
        c = cyc;
        io_buffer_full = 1'b1;
        push_w(32'h30000, 8'h5A, c + 4);
        push_d("sb_io", 0, 32'h0, 3'd0, c + 5);
        fork
            do_data(1'b1, 32'h30000, 32'h0000_005A, F3_B, 3'd0, 1'b1);
            begin
                repeat (4) @(posedge clk);
                #1 io_buffer_full = 1'b0;
            end
        join
        push_d("lbu_io", 1, 32'h0000_005A, 3'd1, cyc + 3);
        do_data(1'b0, 32'h30000, 32'h0, F3_BU, 3'd1, 1'b1);

        push_i("irefill_1000", LINE_1000, 32'h1000, cyc + 18);
        do_inst(32'h1000);
        chk("i_line_word0", 128'(bus.i_line[31:0]), 128'hA3A2A1A0);

        // Concurrent requests; the data side re-requests as soon as its first access completes.
        c = cyc;
        push_d("pair_lbu", 1, 32'h0000_0080, 3'd1, c + 3);
`ifdef MEM_CTRL_RR_EN
        push_i("pair_inst", LINE_1000, 32'h1000, c + 22);
        push_d("pair_lb", 1, 32'hFFFF_FF80, 3'd2, c + 26);
`else
        push_d("pair_lb", 1, 32'hFFFF_FF80, 3'd2, c + 7);
        push_i("pair_inst", LINE_1000, 32'h1000, c + 26);
`endif
        fork
            begin
                do_data(1'b0, 32'h100, 32'h0, F3_BU, 3'd1, 1'b0);
                do_data(1'b0, 32'h100, 32'h0, F3_B, 3'd2, 1'b1);
            end
            do_inst(32'h1000);
        join
        repeat (2) @(posedge clk);
        #1;

        // Refill aborted by flush while byte 9 is on the bus.
        bus.i_req = 1'b1; bus.i_addr = 32'h2000;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_before_flush", 128'(bus.busy), 128'h1);
        bus.flush = 1'b1; bus.i_req = 1'b0;
        push_d("lbu_after_flush", 1, 32'h0000_0080, 3'd3, cyc + 4);
        fork
            do_data(1'b0, 32'h100, 32'h0, F3_BU, 3'd3, 1'b1);
            begin
                @(posedge clk);
                #1 bus.flush = 1'b0;
                chk("busy_after_flush", 128'(bus.busy), 128'h0);
            end
        join

        // Reset in the middle of a word load: no completion may follow.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_funct3 = F3_W; bus.d_id = 3'd4;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid_load", 128'(bus.busy), 128'h1);
        rst_in = 1'b1; bus.d_req = 1'b0;
        @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 128'(bus.busy), 128'h0);
        chk("midrst_d_done", 128'(bus.d_done), 128'h0);
        chk("midrst_mem_aout", 128'(mem_aout), 128'h0);
        repeat (8) @(posedge clk);
        #1;

        chk("done_queue_empty", 128'(exp_q.size()), 128'h0);
        chk("write_queue_empty", 128'(wq.size()), 128'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no end of stimulus required finish before 200000");
        $fatal(1);
    end

endmodule
